// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes per header/instruction word
//   BYTE_IDX_W     : width of the byte-within-word index
//   HDR_LSB_FIRST  : stream byte order (1 = least significant byte first)
//   is_loading()   : states in which a load is in progress
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam bit HDR_LSB_FIRST  = 1'b1;

  function automatic logic is_loading(input state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Stream-in / instruction-RAM-write bundle for the loader.
//   rx_data, rx_valid : byte stream from the source (e.g. UART receiver)
//   rx_ready          : loader can accept a byte
//   is_write          : one-cycle instruction RAM write strobe
//   im_addr, im_inst  : byte address and word for the write
// Handshake: a byte transfers on a rising clock edge where rx_valid and
// rx_ready are both high; while rx_valid is high without rx_ready the source
// must hold rx_data stable; rx_ready never depends combinationally on rx_valid.
// Modports: master = loader side, slave = stream source / RAM side.
interface inst_loader_if #(
  parameter int W = 32
);
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         is_write;
  logic [W-1:0] im_addr;
  logic [W-1:0] im_inst;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output is_write,
    output im_addr,
    output im_inst
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  is_write,
    input  im_addr,
    input  im_inst
  );
endinterface

// File: rtl/byte_packer.sv
// Assembles four stream bytes into a 32-bit word in stream byte order.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of the byte index
//   take       : a byte is accepted this cycle
//   byte_in    : the accepted byte
//   word       : assembled word including byte_in (valid with word_valid)
//   word_valid : combinational pulse, high when take completes a word
// word/word_valid are combinational so the parent FSM can act on the same
// edge that accepts the last byte; the parent registers everything it drives.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [BYTE_IDX_W-1:0] lane;
  logic [31:0]           sr_q;

  // Each byte lands in its own lane; all four lanes are rewritten per word,
  // so stale bytes of the previous word never leak into the next one.
  always_comb begin
    lane = HDR_LSB_FIRST ? idx_q : (BYTE_IDX_W'(BYTES_PER_WORD - 1) - idx_q);
    word = sr_q;
    word[{lane, 3'b000} +: 8] = byte_in;
    word_valid = take && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (take) begin
      sr_q  <= word;
      idx_q <= idx_q + 1'b1;  // wraps 3 -> 0
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader. Receives a little-endian word count N followed
// by N little-endian 32-bit instructions and writes them to instruction RAM
// at BASE, BASE+4, ... while holding the core in reset until the load ends.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : arms a new load from IDLE, DONE or ERR
//   bus         : stream input and instruction RAM write port (master)
//   loading     : load in progress (HDR, DATA, WRITE)
//   done        : load completed, sticky until start or reset
//   err         : header rejected (N==0 or N>DEPTH), sticky until start/reset
//   core_rst_n  : core reset, released only in DONE
//   dbg_state   : current FSM state
// All outputs come straight from flops loaded from the next state.
module inst_loader
  import loader_pkg::*;
#(
  parameter int           W         = 32,
  parameter int           DEPTH     = 2057,
  parameter logic [W-1:0] BASE      = '0,
  parameter bit           AUTOSTART = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  inst_loader_if.master        bus,
  output logic                 loading,
  output logic                 done,
  output logic                 err,
  output logic                 core_rst_n,
  output state_e               dbg_state
);

  localparam int     KW         = $clog2(DEPTH);
  localparam state_e RESET_STATE = AUTOSTART ? ST_HDR : ST_IDLE;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q;
  logic [W-1:0]   count_q;
  logic           rx_ready_q;
  logic           is_write_q;
  logic [W-1:0]   im_addr_q;
  logic [W-1:0]   im_inst_q;
  logic           loading_q, done_q, err_q, core_rst_n_q;

  logic           take;
  logic           rearm;
  logic [31:0]    word;
  logic           word_valid;
  logic           hdr_bad;
  logic           last_word;

  assign take  = bus.rx_valid && rx_ready_q;
  assign rearm = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                           state_q == ST_ERR);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (rearm),
    .take       (take),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Count is range-checked at full width so e.g. 0x0100_0001 is rejected
  // rather than aliasing to a small legal value.
  assign hdr_bad   = (word == '0) || (word > W'(DEPTH));
  assign last_word = ({{(W-KW){1'b0}}, k_q} == (count_q - W'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_HDR;
      ST_HDR:   if (word_valid) state_d = hdr_bad ? ST_ERR : ST_DATA;
      ST_DATA:  if (word_valid) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word ? ST_DONE : ST_DATA;
      ST_DONE:  if (start) state_d = ST_HDR;
      ST_ERR:   if (start) state_d = ST_HDR;
      default:  state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      k_q          <= '0;
      count_q      <= '0;
      rx_ready_q   <= 1'b0;
      is_write_q   <= 1'b0;
      im_addr_q    <= '0;
      im_inst_q    <= '0;
      loading_q    <= AUTOSTART;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= (state_d == ST_HDR) || (state_d == ST_DATA);
      is_write_q   <= (state_d == ST_WRITE);
      loading_q    <= is_loading(state_d);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERR);
      core_rst_n_q <= (state_d == ST_DONE);

      if (state_q == ST_HDR && word_valid) begin
        count_q <= word;
        k_q     <= '0;
      end

      // Address/data are captured on the edge that enters WRITE so they are
      // valid together with is_write and then hold until the next word.
      if (state_q == ST_DATA && word_valid) begin
        im_inst_q <= word;
        im_addr_q <= BASE + {{(W-KW-2){1'b0}}, k_q, 2'b00};
      end

      if (state_q == ST_WRITE && !last_word) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.is_write = is_write_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_inst  = im_inst_q;
  assign loading      = loading_q;
  assign done         = done_q;
  assign err          = err_q;
  assign core_rst_n   = core_rst_n_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;
  import loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       sel = 1'b0;       // 0: drive/observe dut0, 1: dut1
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  int         gap_max = 0;

  inst_loader_if #(.W(32)) if0 ();
  inst_loader_if #(.W(32)) if1 ();

  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid && !sel;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid && sel;

  logic   loading0, done0, err0, core0;
  logic   loading1, done1, err1, core1;
  state_e st0, st1;

  inst_loader #(.W(32), .DEPTH(2057), .BASE(32'h0), .AUTOSTART(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(if0),
    .loading(loading0), .done(done0), .err(err0), .core_rst_n(core0),
    .dbg_state(st0)
  );

  inst_loader #(.W(32), .DEPTH(2057), .BASE(32'h100), .AUTOSTART(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(if1),
    .loading(loading1), .done(done1), .err(err1), .core_rst_n(core1),
    .dbg_state(st1)
  );

  logic        w_rdy, w_is_write, w_done;
  logic [31:0] w_addr, w_inst;
  assign w_rdy      = sel ? if1.rx_ready : if0.rx_ready;
  assign w_is_write = sel ? if1.is_write : if0.is_write;
  assign w_addr     = sel ? if1.im_addr  : if0.im_addr;
  assign w_inst     = sel ? if1.im_inst  : if0.im_inst;
  assign w_done     = sel ? done1        : done0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: expected {addr, inst} writes ----------------
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        prev_wr = 1'b0;
  int          wr_cnt = 0;

  always @(negedge clk) begin
    if (w_is_write) begin
      check("write_pulse_width", {31'b0, prev_wr}, 32'd0);
      check("write_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr", w_addr, mon_e[63:32]);
        check("write_inst", w_inst, mon_e[31:0]);
      end
      wr_cnt++;
    end
    prev_wr = w_is_write;
  end

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after the transfer
  // with rx_valid still high so consecutive calls stream back to back.
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_max > 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!w_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rx_ready_timeout", {31'b0, w_rdy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start(input logic which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!w_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, w_done}, 32'd1);
  endtask

  logic [7:0] vec2 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h05, 8'h10, 8'h00,
                            8'h93, 8'h05, 8'h20, 8'h00};
  int wr_base;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values ----
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", {31'b0, if0.rx_ready}, 32'd0);
    check("rst_is_write", {31'b0, if0.is_write}, 32'd0);
    check("rst_im_addr", if0.im_addr, 32'd0);
    check("rst_im_inst", if0.im_inst, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_err", {31'b0, err0}, 32'd0);
    check("rst_core_rst_n", {31'b0, core0}, 32'd0);
    check("rst_loading_auto", {31'b0, loading0}, 32'd1);
    check("rst_loading_noauto", {31'b0, loading1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rdy_at_release", {31'b0, if0.rx_ready}, 32'd0);
    @(negedge clk);
    check("rdy_after_release", {31'b0, if0.rx_ready}, 32'd1);
    check("idle_rdy", {31'b0, if1.rx_ready}, 32'd0);
    check("idle_state", {29'b0, st1}, {29'b0, ST_IDLE});

    // ---- two-word load ----
    exp_q.push_back({32'h0, 32'h00100513});
    exp_q.push_back({32'h4, 32'h00200593});
    for (int i = 0; i < 12; i++) send_byte(vec2[i]);
    rx_valid = 1'b0;
    check("t2_last_write", {31'b0, if0.is_write}, 32'd1);
    check("t2_done_before", {31'b0, done0}, 32'd0);
    @(negedge clk);
    check("t2_done", {31'b0, done0}, 32'd1);
    check("t2_core_rst_n", {31'b0, core0}, 32'd1);
    check("t2_write_low", {31'b0, if0.is_write}, 32'd0);
    check("t2_loading", {31'b0, loading0}, 32'd0);
    check("t2_wr_cnt", wr_cnt, 32'd2);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("t2_done_no_accept", {31'b0, if0.rx_ready}, 32'd0);
    check("t2_done_state", {29'b0, st0}, {29'b0, ST_DONE});
    rx_valid = 1'b0;

    // ---- re-arm from DONE, three words with random gaps ----
    pulse_start(1'b0);
    check("t3_done_drop", {31'b0, done0}, 32'd0);
    check("t3_core_drop", {31'b0, core0}, 32'd0);
    check("t3_loading", {31'b0, loading0}, 32'd1);
    wr_base = wr_cnt;
    gap_max = 3;
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    exp_q.push_back({32'h4, 32'h12345678});
    exp_q.push_back({32'h8, 32'h00000013});
    send_word(32'd3);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    send_word(32'h00000013);
    rx_valid = 1'b0;
    gap_max = 0;
    wait_done("t3_done");
    check("t3_wr_cnt", wr_cnt - wr_base, 32'd3);

    // ---- bad headers ----
    wr_base = wr_cnt;
    pulse_start(1'b0);
    send_word(32'd0);
    rx_valid = 1'b0;
    check("n0_err", {31'b0, err0}, 32'd1);
    check("n0_core", {31'b0, core0}, 32'd0);
    check("n0_rdy", {31'b0, if0.rx_ready}, 32'd0);
    check("n0_loading", {31'b0, loading0}, 32'd0);
    pulse_start(1'b0);
    check("err_cleared", {31'b0, err0}, 32'd0);
    send_word(32'd2058);
    rx_valid = 1'b0;
    check("n2058_err", {31'b0, err0}, 32'd1);
    check("n2058_core", {31'b0, core0}, 32'd0);
    pulse_start(1'b0);
    send_word(32'h0100_0001);
    rx_valid = 1'b0;
    check("nwide_err", {31'b0, err0}, 32'd1);
    check("err_no_writes", wr_cnt - wr_base, 32'd0);

    // ---- reset mid-word ----
    pulse_start(1'b0);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {31'b0, if0.rx_ready}, 32'd0);
    check("mid_rst_loading", {31'b0, loading0}, 32'd1);
    check("mid_rst_state", {29'b0, st0}, {29'b0, ST_HDR});
    check("mid_rst_addr", if0.im_addr, 32'd0);
    check("mid_rst_core", {31'b0, core0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_base = wr_cnt;
    exp_q.push_back({32'h0, 32'hAAAA5555});
    exp_q.push_back({32'h4, 32'h0BADF00D});
    send_word(32'd2);
    send_word(32'hAAAA5555);
    send_word(32'h0BADF00D);
    rx_valid = 1'b0;
    wait_done("mid_rst_reload_done");
    check("mid_rst_wr_cnt", wr_cnt - wr_base, 32'd2);

    // ---- dut1: BASE=0x100, manual start ----
    sel = 1'b1;
    @(negedge clk);
    check("d1_idle_loading", {31'b0, loading1}, 32'd0);
    pulse_start(1'b1);
    check("d1_armed_loading", {31'b0, loading1}, 32'd1);
    check("d1_armed_rdy", {31'b0, if1.rx_ready}, 32'd1);
    exp_q.push_back({32'h100, 32'h00000013});
    send_word(32'd1);
    send_word(32'h00000013);
    rx_valid = 1'b0;
    wait_done("d1_first_done");
    start1 = 1'b1;
    check("d1_core_before_start", {31'b0, core1}, 32'd1);
    @(posedge clk);
    #1;
    check("d1_done_drop", {31'b0, done1}, 32'd0);
    check("d1_core_drop", {31'b0, core1}, 32'd0);
    @(negedge clk);
    start1 = 1'b0;
    wr_base = wr_cnt;
    exp_q.push_back({32'h100, 32'h11111111});
    exp_q.push_back({32'h104, 32'h22222222});
    send_word(32'd2);
    rx_valid = 1'b0;
    pulse_start(1'b1);   // ignored while loading
    check("d1_start_ignored", {29'b0, st1}, {29'b0, ST_DATA});
    send_word(32'h11111111);
    send_word(32'h22222222);
    rx_valid = 1'b0;
    wait_done("d1_second_done");
    check("d1_wr_cnt", wr_cnt - wr_base, 32'd2);
    check("d1_core", {31'b0, core1}, 32'd1);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader sitting directly upstream of the instruction RAM write port. It accepts a byte stream (e.g. from a UART receiver) carrying a little-endian word count followed by little-endian 32-bit instructions. It drives `is_write`/`im_addr`/`im_inst` to fill instruction memory at consecutive word addresses, and holds the core in reset until the load completes.

## Interface
Parameters:
- `W`, 32, data/address width; must be 32.
- `DEPTH`, 2057, maximum loadable words; must match instruction RAM depth.
- `BASE`, 32'h0, byte address of the first word written.
- `AUTOSTART`, 1, 1: leave reset in HDR; 0: leave reset in IDLE and wait for `start`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on `rx_valid && rx_ready`.
- `is_write`  out  1  instruction RAM write strobe.
- `im_addr`  out  W  byte address of the write.
- `im_inst`  out  W  instruction word to write.
- `loading`  out  1  high in HDR, DATA and WRITE.
- `done`  out  1  load completed successfully; sticky until `start` or reset.
- `err`  out  1  header rejected; sticky until `start` or reset.
- `core_rst_n`  out  1  core reset; low except in DONE.

## Operation
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- Reset (async, `rst_n`=0):
  - state = HDR if `AUTOSTART` else IDLE.
  - All outputs 0, except `loading` = `AUTOSTART`.
  - Byte index, word index, shift register and count cleared.
- IDLE: `rx_ready`=0. `start` -> HDR.
- HDR: `rx_ready`=1. Four accepted bytes form N, LSB first.
  - N==0 or N>DEPTH -> ERR.
  - Otherwise -> DATA with word index k=0.
- DATA: `rx_ready`=1. Four accepted bytes form the word, LSB first. On the 4th byte -> WRITE.
- WRITE: `rx_ready`=0. `is_write`=1 for exactly one cycle with `im_addr` = BASE + 4·k (mod 2^W) and `im_inst` = the assembled word.
  - k==N-1 -> DONE.
  - Otherwise k++ -> DATA.
- DONE: `done`=1, `core_rst_n`=1, `rx_ready`=0. Further bytes are not accepted. `start` -> HDR.
- ERR: `err`=1, `core_rst_n`=0, `rx_ready`=0. `start` -> HDR.
- Re-arm behaviour: `start` in DONE/ERR clears `done`/`err` and drives `core_rst_n` low on the same edge that enters HDR. `start` in HDR/DATA/WRITE is ignored.
- `im_addr`/`im_inst` hold their last values outside WRITE and are don't-care when `is_write`=0.
- Byte index is 2 bits and wraps 3->0. k is $clog2(DEPTH) bits. N is compared at full 32 bits; there is no truncation before the range check.

## Timing
- All outputs are registered; none is combinational from inputs.
- `is_write` rises the cycle after the 4th data byte is accepted.
- Minimum 5 cycles per word (4 bytes + 1 write cycle). Gaps in `rx_valid` stall the FSM indefinitely without state change.
- Final write: `done` and `core_rst_n` rise in the cycle immediately after the last `is_write` cycle.
- ERR is entered in the cycle after the 4th header byte; `err` is visible then.
- `rx_valid` without `rx_ready` means no transfer; the source must hold the byte.
- `rst_n` asserted mid-load aborts immediately. Partially written RAM contents are left as-is; the next load overwrites them.

## Structure
- Shared package `loader_pkg`: state enum, `BYTES_PER_WORD`=4, header byte order constant.
- One sub-module is natural: `byte_packer` (4-byte little-endian shift register + 2-bit index, `word_valid` pulse). It is reused for both header and data words.

## Test plan
- Reset values: `rst_n` low -> all outputs 0, `loading`=1 with `AUTOSTART`=1; `rx_ready` rises one cycle after release.
- Two-word load: bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> writes (0x0, 0x00100513) then (0x4, 0x00200593); `done`=`core_rst_n`=1 the cycle after the second write.
- Irregular `rx_valid` with random gaps during a 3-word load -> identical writes; exactly 3 `is_write` pulses, each one cycle wide.
- Header N=0, and separately N=2058 -> `err`=1, no `is_write`, `core_rst_n` stays 0.
- Reset mid-word, after 2 data bytes -> outputs reset immediately; fresh header plus words load correctly from `BASE`.
- `start` in DONE -> `done` and `core_rst_n` drop the same edge; a second load with `BASE`=0x100 writes 0x100, 0x104.
